// File: rtl/proc_source_arrayed_sig_if.sv
// Frame-in / stream-out bundle for proc_source_arrayed_sig.
// The master side offers frames and consumes beats; the slave side is the source block.
interface proc_source_arrayed_sig_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
);
    logic [WIDTH*DEPTH-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic [7:0]             frames_done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, frames_done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, frames_done
    );
endinterface

// File: rtl/proc_source_arrayed_sig.sv
// Captures a packed frame {mem[0]..mem[DEPTH-1]} and replays it one entry per beat with a last flag.
// Optional trailing XOR checksum beat is compiled in with PROC_SOURCE_CSUM_EN.
module proc_source_arrayed_sig #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    proc_source_arrayed_sig_if.slave        bus
);
`ifdef PROC_SOURCE_CSUM_EN
    typedef enum logic [1:0] {IDLE, STREAM, CSUM} state_t;
`else
    typedef enum logic {IDLE, STREAM} state_t;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] frame_entry [DEPTH];
    logic [IDX_W-1:0] idx_nxt;
    logic             beat_taken;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic [7:0]       frames_done_q;

`ifdef PROC_SOURCE_CSUM_EN
    logic [WIDTH-1:0] csum;
    logic [WIDTH-1:0] csum_in;
`endif

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            frame_entry[i] = bus.in_data[(DEPTH-1-i)*WIDTH +: WIDTH];
        end
        idx_nxt    = idx + 1'b1;
        beat_taken = out_valid_q && bus.out_ready;
`ifdef PROC_SOURCE_CSUM_EN
        csum_in = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            csum_in = csum_in ^ frame_entry[i];
        end
`endif
    end

    // Outputs are registered: each transition loads the values the next state presents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            frames_done_q <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
`ifdef PROC_SOURCE_CSUM_EN
            csum          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= frame_entry[i];
                        idx         <= '0;
                        state       <= STREAM;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= frame_entry[0];
                        out_last_q  <= 1'b0;
`ifdef PROC_SOURCE_CSUM_EN
                        csum        <= csum_in;
`endif
                    end
                end
                STREAM: begin
                    if (beat_taken) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
`ifdef PROC_SOURCE_CSUM_EN
                            state       <= CSUM;
                            out_data_q  <= csum;
                            out_last_q  <= 1'b1;
`else
                            state         <= IDLE;
                            frames_done_q <= frames_done_q + 1'b1;
                            in_ready_q    <= 1'b1;
                            out_valid_q   <= 1'b0;
                            out_data_q    <= '0;
                            out_last_q    <= 1'b0;
`endif
                        end else begin
                            idx        <= idx_nxt;
                            out_data_q <= mem[idx_nxt];
`ifdef PROC_SOURCE_CSUM_EN
                            out_last_q <= 1'b0;
`else
                            out_last_q <= (idx_nxt == LAST_IDX);
`endif
                        end
                    end
                end
`ifdef PROC_SOURCE_CSUM_EN
                CSUM: begin
                    if (beat_taken) begin
                        state         <= IDLE;
                        frames_done_q <= frames_done_q + 1'b1;
                        in_ready_q    <= 1'b1;
                        out_valid_q   <= 1'b0;
                        out_data_q    <= '0;
                        out_last_q    <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.frames_done = frames_done_q;
endmodule

// File: tb/tb_proc_source_arrayed_sig.sv
// Directed bench for proc_source_arrayed_sig; expected beats follow PROC_SOURCE_CSUM_EN when defined.
module tb_proc_source_arrayed_sig;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [7:0] exp_frames;

    proc_source_arrayed_sig_if #(.WIDTH(2), .DEPTH(4)) bus ();

    proc_source_arrayed_sig #(.WIDTH(2), .DEPTH(4), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},    32'(bus.in_ready),    32'd1);
        check({tag, ".out_valid"},   32'(bus.out_valid),   32'd0);
        check({tag, ".out_data"},    32'(bus.out_data),    32'd0);
        check({tag, ".out_last"},    32'(bus.out_last),    32'd0);
        check({tag, ".frames_done"}, 32'(bus.frames_done), 32'(exp_frames));
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the final beat.
    task automatic send_frame(input logic [7:0] d, input int stall_beat, input int stall_n,
                              input bit inject);
        logic [1:0] exp_beat [5];
        logic [1:0] x;
        int nb;
        x = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_beat[i] = d[(3-i)*2 +: 2];
            x = x ^ exp_beat[i];
        end
        exp_beat[4] = x;
`ifdef PROC_SOURCE_CSUM_EN
        nb = 5;
`else
        nb = 4;
`endif
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = inject;
        bus.in_data  = 8'hFF;
        for (int b = 0; b < nb; b++) begin
            if (b == stall_beat) begin
                bus.out_ready = 1'b0;
                repeat (stall_n) begin
                    check("stall.out_valid", 32'(bus.out_valid), 32'd1);
                    check("stall.out_data",  32'(bus.out_data),  32'(exp_beat[b]));
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
            check("beat.in_ready",  32'(bus.in_ready),  32'd0);
            check("beat.out_valid", 32'(bus.out_valid), 32'd1);
            check("beat.out_data",  32'(bus.out_data),  32'(exp_beat[b]));
            check("beat.out_last",  32'(bus.out_last),  32'(b == nb - 1));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        exp_frames   = exp_frames + 8'd1;
        check_idle("post_frame");
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        exp_frames    = 8'd0;
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        bus.out_ready = 1'b1;

        // Held in reset with a frame offered: nothing captured.
        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("release");
        end

        // Plain frame, back-to-back beats.
        send_frame(8'b00_01_10_11, -1, 0, 1'b0);
        // Backpressure on the second beat.
        send_frame(8'b00_01_10_11, 1, 3, 1'b0);
        // Frame offers during streaming are ignored.
        send_frame(8'b00_01_10_11, -1, 0, 1'b1);
        // Checksum-pattern frames (plain frames when the checksum beat is absent).
        send_frame(8'b11_01_10_11, -1, 0, 1'b0);
        send_frame(8'b10_11_00_01, 2, 1, 1'b1);

        // Asynchronous reset after the second handshake.
        bus.in_data  = 8'b00_01_10_11;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort.out_data", 32'(bus.out_data), 32'd2);
        #2 rst = 1'b0;
        #1;
        exp_frames = 8'd0;
        check("abort.out_valid",   32'(bus.out_valid),   32'd0);
        check("abort.out_data",    32'(bus.out_data),    32'd0);
        check("abort.frames_done", 32'(bus.frames_done), 32'd0);
        check("abort.in_ready",    32'(bus.in_ready),    32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_abort");

        // Counter wrap after 256 frames.
        for (int f = 0; f < 256; f++) begin
            send_frame(8'(f), -1, 0, 1'b0);
        end
        check("wrap.frames_done", 32'(bus.frames_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
